// File: rtl/summer_pkg.sv
// Shared widths, job record and controller state encoding for the summer dispatcher.
package summer_pkg;

  localparam int D_W   = 5;
  localparam int BIN_W = 64;
  localparam int BCD_W = 80;

  typedef struct packed {
    logic [D_W-1:0]   d;
    logic [BIN_W-1:0] range_start;
    logic [BIN_W-1:0] range_end;
    logic [BCD_W-1:0] lower_bcd;
    logic [BCD_W-1:0] upper_bcd;
  } job_t;

  localparam int JOB_W = $bits(job_t);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/job_fifo.sv
// Synchronous job queue; head is read straight from the storage registers.
// A pop frees its slot in the same edge, so push+pop while full is accepted.
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/summer_dispatch.sv
// Queues range-sum jobs, hands them round-robin to idle lanes, and accumulates lane results.
// One dispatch per edge; a lane is eligible again the edge after its lane_done is taken.
module summer_dispatch
  import summer_pkg::*;
#(
  parameter int N_LANES    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [D_W-1:0]           job_d,
  input  logic [BIN_W-1:0]         job_start,
  input  logic [BIN_W-1:0]         job_end,
  input  logic [BCD_W-1:0]         job_lower_bcd,
  input  logic [BCD_W-1:0]         job_upper_bcd,
  input  logic                     job_last,
  output logic [N_LANES-1:0]       lane_start,
  output logic [D_W*N_LANES-1:0]   lane_d,
  output logic [BIN_W*N_LANES-1:0] lane_range_start,
  output logic [BIN_W*N_LANES-1:0] lane_range_end,
  output logic [BCD_W*N_LANES-1:0] lane_lower_bcd,
  output logic [BCD_W*N_LANES-1:0] lane_upper_bcd,
  input  logic [N_LANES-1:0]       lane_done,
  input  logic [BIN_W*N_LANES-1:0] lane_p1_sum,
  input  logic [BIN_W*N_LANES-1:0] lane_p2_sum,
  output logic [BIN_W-1:0]         part1_result,
  output logic [BIN_W-1:0]         part2_result,
  output logic                     done,
  output logic                     busy
);

  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [N_LANES-1:0] lane_busy_q, lane_busy_d;
  logic [N_LANES-1:0] lane_start_q, lane_start_d;
  logic [LW-1:0]    rr_q, rr_d;
  logic [BIN_W-1:0] part1_q, part1_d, part2_q, part2_d;
  job_t             lane_job_q [N_LANES];

  job_t             job_in, fifo_head;
  logic             fifo_full, fifo_empty;
  logic [FAW:0]     fifo_count;
  logic             accept, dispatch, drained;
  logic             grant_found;
  logic [LW-1:0]    grant_idx, cand;

  assign job_in = '{d: job_d, range_start: job_start, range_end: job_end,
                    lower_bcd: job_lower_bcd, upper_bcd: job_upper_bcd};
  assign accept = job_valid && job_ready;

  job_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(JOB_W)) u_job_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept),
    .push_dat_i (job_in),
    .pop_i      (dispatch),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // rr_q holds the lane where the next search begins, not the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_LANES; k++) begin
      cand = LW'((int'(rr_q) + k) % N_LANES);
      if (!grant_found && !lane_busy_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign dispatch = !fifo_empty && grant_found;

  always_comb begin
    lane_busy_d  = lane_busy_q;
    lane_start_d = '0;
    rr_d         = rr_q;
    part1_d      = part1_q;
    part2_d      = part2_q;
    for (int i = 0; i < N_LANES; i++) begin
      if (lane_busy_q[i] && lane_done[i]) begin
        lane_busy_d[i] = 1'b0;
        part1_d = part1_d + lane_p1_sum[i*BIN_W +: BIN_W];
        part2_d = part2_d + lane_p2_sum[i*BIN_W +: BIN_W];
      end
    end
    if (dispatch) begin
      lane_busy_d[grant_idx]  = 1'b1;
      lane_start_d[grant_idx] = 1'b1;
      rr_d = (grant_idx == LW'(N_LANES-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_busy_q  <= '0;
      lane_start_q <= '0;
      rr_q         <= '0;
      part1_q      <= '0;
      part2_q      <= '0;
      for (int i = 0; i < N_LANES; i++) lane_job_q[i] <= '0;
    end else begin
      lane_busy_q  <= lane_busy_d;
      lane_start_q <= lane_start_d;
      rr_q         <= rr_d;
      part1_q      <= part1_d;
      part2_q      <= part2_d;
      if (dispatch) lane_job_q[grant_idx] <= fifo_head;
    end
  end

  // Controller: state register, next-state logic, output decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign drained = (fifo_count == '0) && !(|lane_busy_q) && !(|lane_start_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = job_last ? S_DRAIN : S_RUN;
      S_RUN:   if (accept && job_last) state_d = S_DRAIN;
      S_DRAIN: if (drained) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    job_ready = ((state_q == S_IDLE) || (state_q == S_RUN)) && !fifo_full;
    done_d    = (state_d == S_DONE);
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    assign lane_d[g*D_W +: D_W]                = lane_job_q[g].d;
    assign lane_range_start[g*BIN_W +: BIN_W]  = lane_job_q[g].range_start;
    assign lane_range_end[g*BIN_W +: BIN_W]    = lane_job_q[g].range_end;
    assign lane_lower_bcd[g*BCD_W +: BCD_W]    = lane_job_q[g].lower_bcd;
    assign lane_upper_bcd[g*BCD_W +: BCD_W]    = lane_job_q[g].upper_bcd;
  end

  assign lane_start   = lane_start_q;
  assign part1_result = part1_q;
  assign part2_result = part2_q;
  assign done         = done_q;
  assign busy         = (|lane_busy_q) || !fifo_empty;

endmodule

// File: tb/tb_summer_dispatch.sv
// Directed bench for summer_dispatch with stub lanes that answer after a programmable latency.
module tb_summer_dispatch;

  localparam int NL = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              job_valid, job_ready, job_last;
  logic [4:0]        job_d;
  logic [63:0]       job_start, job_end;
  logic [79:0]       job_lower_bcd, job_upper_bcd;
  logic [NL-1:0]     lane_start, lane_done;
  logic [5*NL-1:0]   lane_d;
  logic [64*NL-1:0]  lane_range_start, lane_range_end, lane_p1_sum, lane_p2_sum;
  logic [80*NL-1:0]  lane_lower_bcd, lane_upper_bcd;
  logic [63:0]       part1_result, part2_result;
  logic              done, busy;

  logic [NL-1:0]     stub_done, man_done;
  logic [64*NL-1:0]  stub_p1, stub_p2, man_p1, man_p2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign lane_done   = stub_done | man_done;
  assign lane_p1_sum = stub_p1 | man_p1;
  assign lane_p2_sum = stub_p2 | man_p2;

  summer_dispatch #(.N_LANES(NL), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_d(job_d),
    .job_start(job_start), .job_end(job_end),
    .job_lower_bcd(job_lower_bcd), .job_upper_bcd(job_upper_bcd), .job_last(job_last),
    .lane_start(lane_start), .lane_d(lane_d),
    .lane_range_start(lane_range_start), .lane_range_end(lane_range_end),
    .lane_lower_bcd(lane_lower_bcd), .lane_upper_bcd(lane_upper_bcd),
    .lane_done(lane_done), .lane_p1_sum(lane_p1_sum), .lane_p2_sum(lane_p2_sum),
    .part1_result(part1_result), .part2_result(part2_result),
    .done(done), .busy(busy)
  );

  // Stub lanes: return the sums tabulated for the job's range_start.
  logic [63:0] p1_tab [logic [63:0]];
  logic [63:0] p2_tab [logic [63:0]];
  bit          stub_en = 1'b0;
  int          stub_lat = 5;
  int          cnt [NL];
  bit          act [NL];
  logic [63:0] key [NL];

  initial begin
    stub_done = '0;
    stub_p1   = '0;
    stub_p2   = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
        stub_done[i] = 1'b0;
        stub_p1[i*64 +: 64] = '0;
        stub_p2[i*64 +: 64] = '0;
        if (act[i]) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) begin
            act[i] = 1'b0;
            stub_done[i] = 1'b1;
            stub_p1[i*64 +: 64] = p1_tab[key[i]];
            stub_p2[i*64 +: 64] = p2_tab[key[i]];
          end
        end
        if (stub_en && lane_start[i]) begin
          act[i] = 1'b1;
          cnt[i] = stub_lat;
          key[i] = lane_range_start[i*64 +: 64];
        end
      end
    end
  end

  int grants[$];
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) if (lane_start[i]) grants.push_back(i);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    job_valid = 1'b0; job_last = 1'b0; job_d = '0;
    job_start = '0; job_end = '0; job_lower_bcd = '0; job_upper_bcd = '0;
    man_done = '0; man_p1 = '0; man_p2 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    grants.delete();
  endtask

  task automatic push_job(input logic [4:0] d, input logic [63:0] s, input logic [63:0] e,
                          input logic [79:0] lo, input logic [79:0] hi, input logic last);
    bit acc;
    acc = 1'b0;
    job_d = d; job_start = s; job_end = e;
    job_lower_bcd = lo; job_upper_bcd = hi; job_last = last;
    job_valid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      acc = job_ready;
      @(negedge clk);
    end
    job_valid = 1'b0;
    job_last  = 1'b0;
    if (!acc) begin
      total_cnt++;
      $display("FAIL push_timeout: job start=%0d never accepted (ready=%b, required 1)", s, job_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (part1_result !== 64'd0) $display("FAIL rst_part1: got %h want 0", part1_result); else pass_cnt++;
    total_cnt++; if (part2_result !== 64'd0) $display("FAIL rst_part2: got %h want 0", part2_result); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (lane_start !== 2'b00) $display("FAIL rst_lane_start: got %b want 00", lane_start); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (job_ready !== 1'b1) $display("FAIL rst_job_ready: got %b want 1", job_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    int tpulse, tdone;
    do_reset();
    p1_tab[64'd10] = 64'd495;
    p2_tab[64'd10] = 64'd495;
    stub_en = 1'b1; stub_lat = 5;
    tpulse = -1; tdone = -1;
    push_job(5'd2, 64'd10, 64'd99, 80'h10, 80'h99, 1'b1);
    for (int c = 0; c < 100 && tdone < 0; c++) begin
      @(negedge clk); #1;
      if (|lane_done && tpulse < 0) tpulse = c;
      if (done === 1'b1) tdone = c;
    end
    total_cnt++; if (tdone < 0 || tpulse < 0 || tdone - tpulse > 2 || tdone <= tpulse)
      $display("FAIL single_done_latency: done at %0d, lane_done at %0d (want within 2 cycles)", tdone, tpulse); else pass_cnt++;
    total_cnt++; if (part1_result !== 64'd495) $display("FAIL single_part1: got %0d want 495", part1_result); else pass_cnt++;
    total_cnt++; if (part2_result !== 64'd495) $display("FAIL single_part2: got %0d want 495", part2_result); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (job_ready !== 1'b0) $display("FAIL single_ready_done: got %b want 0", job_ready); else pass_cnt++;
    total_cnt++; if (lane_d[4:0] !== 5'd2 || lane_range_start[63:0] !== 64'd10 || lane_range_end[63:0] !== 64'd99)
      $display("FAIL single_operands: d=%0d start=%0d end=%0d want 2/10/99", lane_d[4:0], lane_range_start[63:0], lane_range_end[63:0]); else pass_cnt++;
    total_cnt++; if (lane_lower_bcd[79:0] !== 80'h10 || lane_upper_bcd[79:0] !== 80'h99)
      $display("FAIL single_bcd: lo=%h hi=%h want 10/99", lane_lower_bcd[79:0], lane_upper_bcd[79:0]); else pass_cnt++;
    total_cnt++; if (grants.size() != 1 || grants[0] != 0)
      $display("FAIL single_grant: %0d grants, first=%0d want 1 grant to lane 0", grants.size(), (grants.size() > 0) ? grants[0] : -1); else pass_cnt++;
    stub_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int waited;
    do_reset();
    stub_en = 1'b1; stub_lat = 20;
    for (int k = 1; k <= 6; k++) begin
      p1_tab[64'(k)] = 64'(1 << (k-1));
      p2_tab[64'(k)] = 64'(100 * k);
    end
    for (int k = 1; k <= 6; k++) push_job(5'd1, 64'(k), 64'(k), 80'(k), 80'(k), k == 6);
    #1;
    total_cnt++; if (job_ready !== 1'b0) $display("FAIL b2b_ready_full: got %b want 0", job_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else pass_cnt++;
    waited = 0;
    while (done !== 1'b1 && waited < 400) begin @(negedge clk); #1; waited++; end
    total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done); else pass_cnt++;
    total_cnt++; if (part1_result !== 64'd63) $display("FAIL b2b_part1: got %0d want 63", part1_result); else pass_cnt++;
    total_cnt++; if (part2_result !== 64'd2100) $display("FAIL b2b_part2: got %0d want 2100", part2_result); else pass_cnt++;
    total_cnt++; if (grants.size() != 6) $display("FAIL b2b_grant_count: got %0d want 6", grants.size()); else pass_cnt++;
    for (int k = 0; k < 6 && k < grants.size(); k++) begin
      total_cnt++; if (grants[k] != k % 2) $display("FAIL b2b_grant%0d: lane %0d want %0d", k, grants[k], k % 2); else pass_cnt++;
    end
    stub_en = 1'b0;
  endtask

  task automatic test_simultaneous_and_idle();
    do_reset();
    push_job(5'd3, 64'd20, 64'd29, 80'h0, 80'h0, 1'b0);
    push_job(5'd3, 64'd21, 64'd29, 80'h0, 80'h0, 1'b0);
    repeat (3) @(negedge clk);
    man_done = 2'b11;
    man_p1 = {64'd200, 64'd100};
    man_p2 = {64'd6, 64'd5};
    @(negedge clk);
    man_done = '0; man_p1 = '0; man_p2 = '0;
    #1;
    total_cnt++; if (part1_result !== 64'd300) $display("FAIL simul_part1: got %0d want 300", part1_result); else pass_cnt++;
    total_cnt++; if (part2_result !== 64'd11) $display("FAIL simul_part2: got %0d want 11", part2_result); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL simul_busy: got %b want 0", busy); else pass_cnt++;
    man_done = 2'b01;
    man_p1 = {64'd0, 64'd7};
    @(negedge clk);
    man_done = '0; man_p1 = '0;
    @(negedge clk); #1;
    total_cnt++; if (part1_result !== 64'd300) $display("FAIL idle_done_part1: got %0d want 300", part1_result); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    push_job(5'd4, 64'd40, 64'd49, 80'h0, 80'h0, 1'b0);
    push_job(5'd4, 64'd41, 64'd49, 80'h0, 80'h0, 1'b0);
    repeat (3) @(negedge clk);
    man_done = 2'b01;
    man_p1 = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    man_p2 = {64'd0, 64'd3};
    @(negedge clk);
    man_done = 2'b10;
    man_p1 = {64'd2, 64'd0};
    man_p2 = {64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    @(negedge clk);
    man_done = '0; man_p1 = '0; man_p2 = '0;
    #1;
    total_cnt++; if (part1_result !== 64'd1) $display("FAIL wrap_part1: got %h want 1", part1_result); else pass_cnt++;
    total_cnt++; if (part2_result !== 64'd2) $display("FAIL wrap_part2: got %h want 2", part2_result); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    stub_en = 1'b1; stub_lat = 20;
    for (int k = 30; k < 35; k++) begin
      p1_tab[64'(k)] = 64'd9;
      p2_tab[64'(k)] = 64'd9;
    end
    for (int k = 30; k < 35; k++) push_job(5'd5, 64'(k), 64'd99, 80'h0, 80'h0, 1'b0);
    #1;
    total_cnt++; if (busy !== 1'b1 || lane_range_start[63:0] !== 64'd30)
      $display("FAIL midrst_pre: busy=%b lane0 start=%0d want 1/30", busy, lane_range_start[63:0]); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    grants.delete();
    total_cnt++; if (busy !== 1'b0 || lane_start !== 2'b00 || done !== 1'b0)
      $display("FAIL midrst_ctrl: busy=%b lane_start=%b done=%b want 0/00/0", busy, lane_start, done); else pass_cnt++;
    total_cnt++; if (lane_range_start !== '0 || lane_d !== '0)
      $display("FAIL midrst_operands: start=%h d=%h want 0", lane_range_start, lane_d); else pass_cnt++;
    total_cnt++; if (job_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", job_ready); else pass_cnt++;
    repeat (30) @(negedge clk);
    #1;
    total_cnt++; if (part1_result !== 64'd0 || part2_result !== 64'd0)
      $display("FAIL midrst_late_done: part1=%0d part2=%0d want 0/0", part1_result, part2_result); else pass_cnt++;
    total_cnt++; if (grants.size() != 0 || busy !== 1'b0)
      $display("FAIL midrst_discard: %0d grants busy=%b want 0/0", grants.size(), busy); else pass_cnt++;
    stub_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    job_valid = 1'b0;
    man_done = '0; man_p1 = '0; man_p2 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_simultaneous_and_idle();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
